// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU/CSR results and aligned loads into the register-file write port.
// Optional retired-instruction counter o_instret is enabled by defining WB_INSTRET_EN.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef XADDR
`define XADDR 5
`endif

module writeback_stage (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_rd_wen,
  input  logic [`XADDR-1:0]   i_rd_addr,
  input  logic [`XLEN-1:0]    i_result,
  input  logic                i_is_load,
  input  logic [2:0]          i_funct3,
  input  logic [1:0]          i_addr_lo,
  input  logic                i_dmem_rvalid,
  input  logic [`XLEN-1:0]    i_dmem_rdata,
`ifdef WB_INSTRET_EN
  output logic [63:0]         o_instret,
`endif
  output logic                o_wr_en,
  output logic [`XADDR-1:0]   o_rd_addr,
  output logic [`XLEN-1:0]    o_rd_data,
  output logic                o_load_fault
);

  localparam int XLEN  = `XLEN;
  localparam int XADDR = `XADDR;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t             state;

  // Context of the load currently waiting for its memory response.
  logic               ld_wen;
  logic [XADDR-1:0]   ld_addr;
  logic [2:0]         ld_funct3;
  logic [1:0]         ld_addr_lo;

  logic [XLEN-1:0]    load_data;
  logic               load_fault;
  logic [7:0]         lane_byte;
  logic [15:0]        lane_half;

  assign o_ready = i_rst_n && (state == IDLE);

  always_comb begin
    lane_byte  = 8'h00;
    lane_half  = 16'h0000;
    load_data  = '0;
    load_fault = 1'b0;

    case (ld_addr_lo)
      2'd0:    lane_byte = i_dmem_rdata[7:0];
      2'd1:    lane_byte = i_dmem_rdata[15:8];
      2'd2:    lane_byte = i_dmem_rdata[23:16];
      default: lane_byte = i_dmem_rdata[31:24];
    endcase
    lane_half = ld_addr_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

    case (ld_funct3)
      3'b000: load_data = {{(XLEN-8){lane_byte[7]}}, lane_byte};
      3'b100: load_data = {{(XLEN-8){1'b0}}, lane_byte};
      3'b001: begin
        load_data  = {{(XLEN-16){lane_half[15]}}, lane_half};
        load_fault = ld_addr_lo[0];
      end
      3'b101: begin
        load_data  = {{(XLEN-16){1'b0}}, lane_half};
        load_fault = ld_addr_lo[0];
      end
      3'b010: begin
        load_data  = i_dmem_rdata;
        load_fault = (ld_addr_lo != 2'd0);
      end
      default: load_fault = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      o_wr_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_data    <= '0;
      o_load_fault <= 1'b0;
      ld_wen       <= 1'b0;
      ld_addr      <= '0;
      ld_funct3    <= 3'b000;
      ld_addr_lo   <= 2'b00;
`ifdef WB_INSTRET_EN
      o_instret    <= 64'd0;
`endif
    end else begin
      o_wr_en      <= 1'b0;
      o_load_fault <= 1'b0;

      case (state)
        IDLE: begin
          if (i_valid) begin
            if (i_is_load) begin
              ld_wen     <= i_rd_wen;
              ld_addr    <= i_rd_addr;
              ld_funct3  <= i_funct3;
              ld_addr_lo <= i_addr_lo;
              state      <= WAIT_LOAD;
            end else begin
`ifdef WB_INSTRET_EN
              o_instret <= o_instret + 64'd1;
`endif
              // Address/data only move on a real write so they hold the last written value.
              if (i_rd_wen && (i_rd_addr != '0)) begin
                o_wr_en   <= 1'b1;
                o_rd_addr <= i_rd_addr;
                o_rd_data <= i_result;
              end
            end
          end
        end

        WAIT_LOAD: begin
          if (i_dmem_rvalid) begin
            state <= IDLE;
            if (load_fault) begin
              o_load_fault <= 1'b1;
            end else begin
`ifdef WB_INSTRET_EN
              o_instret <= o_instret + 64'd1;
`endif
              if (ld_wen && (ld_addr != '0)) begin
                o_wr_en   <= 1'b1;
                o_rd_addr <= ld_addr;
                o_rd_data <= load_data;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (ALU pass-through, load extraction, faults, x0, reset).
// Define WB_INSTRET_EN to also exercise the retired-instruction counter.

`timescale 1ns/1ps

module tb_writeback_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic        i_rd_wen;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_result;
  logic        i_is_load;
  logic [2:0]  i_funct3;
  logic [1:0]  i_addr_lo;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_wr_en;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic        o_load_fault;
`ifdef WB_INSTRET_EN
  logic [63:0] o_instret;
`endif

  int checks = 0;
  int failures = 0;

  writeback_stage dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_rd_wen      (i_rd_wen),
    .i_rd_addr     (i_rd_addr),
    .i_result      (i_result),
    .i_is_load     (i_is_load),
    .i_funct3      (i_funct3),
    .i_addr_lo     (i_addr_lo),
    .i_dmem_rvalid (i_dmem_rvalid),
    .i_dmem_rdata  (i_dmem_rdata),
`ifdef WB_INSTRET_EN
    .o_instret     (o_instret),
`endif
    .o_wr_en       (o_wr_en),
    .o_rd_addr     (o_rd_addr),
    .o_rd_data     (o_rd_data),
    .o_load_fault  (o_load_fault)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock edge and sample 1 ns after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_valid       = 1'b0;
    i_rd_wen      = 1'b0;
    i_rd_addr     = 5'd0;
    i_result      = 32'd0;
    i_is_load     = 1'b0;
    i_funct3      = 3'b000;
    i_addr_lo     = 2'b00;
    i_dmem_rvalid = 1'b0;
    i_dmem_rdata  = 32'd0;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res, input logic wen);
    i_valid   = 1'b1;
    i_is_load = 1'b0;
    i_rd_wen  = wen;
    i_rd_addr = rd;
    i_result  = res;
  endtask

  // Accept a load, wait one empty cycle, then deliver the response; returns after the write edge.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] data);
    i_valid   = 1'b1;
    i_is_load = 1'b1;
    i_rd_wen  = 1'b1;
    i_rd_addr = rd;
    i_funct3  = f3;
    i_addr_lo = lo;
    tick();
    idle_inputs();
    tick();
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = data;
    tick();
    i_dmem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 0", o_ready);
    end
    checks++;
    if ({o_wr_en, o_load_fault, o_rd_addr, o_rd_data} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs: got wr=%b flt=%b rd=%0d data=%h expected all zero",
               o_wr_en, o_load_fault, o_rd_addr, o_rd_data);
    end
    i_rst_n = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b expected 1", o_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_alu();
    drive_alu(5'd5, 32'h1234ABCD, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd5 || o_rd_data !== 32'h1234ABCD) begin
      failures++;
      $display("FAIL alu_write: got wr=%b rd=%0d data=%h expected wr=1 rd=5 data=1234abcd",
               o_wr_en, o_rd_addr, o_rd_data);
    end
    tick();
    checks++;
    if (o_wr_en !== 1'b0 || o_rd_data !== 32'h1234ABCD) begin
      failures++;
      $display("FAIL alu_pulse_hold: got wr=%b data=%h expected wr=0 data=1234abcd",
               o_wr_en, o_rd_data);
    end
    $display("test_alu done");
  endtask

  task automatic test_back_to_back();
    drive_alu(5'd1, 32'h11111111, 1'b1);
    tick();
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd1 || o_rd_data !== 32'h11111111 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: got wr=%b rd=%0d data=%h rdy=%b expected wr=1 rd=1 data=11111111 rdy=1",
               o_wr_en, o_rd_addr, o_rd_data, o_ready);
    end
    drive_alu(5'd31, 32'hDEADBEEF, 1'b1);
    tick();
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd31 || o_rd_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL b2b_second: got wr=%b rd=%0d data=%h expected wr=1 rd=31 data=deadbeef",
               o_wr_en, o_rd_addr, o_rd_data);
    end
    drive_alu(5'd9, 32'hCAFEF00D, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (o_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_wen: got wr=%b expected 0", o_wr_en);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_lb();
    i_valid   = 1'b1;
    i_is_load = 1'b1;
    i_rd_wen  = 1'b1;
    i_rd_addr = 5'd7;
    i_funct3  = 3'b000;
    i_addr_lo = 2'd3;
    tick();
    idle_inputs();
    checks++;
    if (o_ready !== 1'b0 || o_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL lb_wait1: got rdy=%b wr=%b expected rdy=0 wr=0", o_ready, o_wr_en);
    end
    tick();
    checks++;
    if (o_ready !== 1'b0 || o_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL lb_wait2: got rdy=%b wr=%b expected rdy=0 wr=0", o_ready, o_wr_en);
    end
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'h80FF0011;
    tick();
    i_dmem_rvalid = 1'b0;
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd7 || o_rd_data !== 32'hFFFFFF80 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL lb_write: got wr=%b rd=%0d data=%h rdy=%b expected wr=1 rd=7 data=ffffff80 rdy=1",
               o_wr_en, o_rd_addr, o_rd_data, o_ready);
    end
    tick();
    checks++;
    if (o_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL lb_pulse: got wr=%b expected 0", o_wr_en);
    end
    do_load(5'd8, 3'b100, 2'd0, 32'h80FF0011);
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd8 || o_rd_data !== 32'h00000011) begin
      failures++;
      $display("FAIL lbu_lane0: got wr=%b rd=%0d data=%h expected wr=1 rd=8 data=00000011",
               o_wr_en, o_rd_addr, o_rd_data);
    end
    do_load(5'd8, 3'b100, 2'd3, 32'h80FF0011);
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_data !== 32'h00000080) begin
      failures++;
      $display("FAIL lbu_lane3: got wr=%b data=%h expected wr=1 data=00000080", o_wr_en, o_rd_data);
    end
    $display("test_lb done");
  endtask

  task automatic test_half_word();
    do_load(5'd10, 3'b101, 2'd2, 32'hBEEF1234);
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd10 || o_rd_data !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL lhu_upper: got wr=%b rd=%0d data=%h expected wr=1 rd=10 data=0000beef",
               o_wr_en, o_rd_addr, o_rd_data);
    end
    do_load(5'd11, 3'b001, 2'd2, 32'hBEEF1234);
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd11 || o_rd_data !== 32'hFFFFBEEF) begin
      failures++;
      $display("FAIL lh_upper: got wr=%b rd=%0d data=%h expected wr=1 rd=11 data=ffffbeef",
               o_wr_en, o_rd_addr, o_rd_data);
    end
    do_load(5'd12, 3'b001, 2'd0, 32'hBEEF8234);
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_data !== 32'hFFFF8234) begin
      failures++;
      $display("FAIL lh_lower: got wr=%b data=%h expected wr=1 data=ffff8234", o_wr_en, o_rd_data);
    end
    do_load(5'd13, 3'b010, 2'd0, 32'hA5A55A5A);
    checks++;
    if (o_wr_en !== 1'b1 || o_rd_addr !== 5'd13 || o_rd_data !== 32'hA5A55A5A) begin
      failures++;
      $display("FAIL lw_aligned: got wr=%b rd=%0d data=%h expected wr=1 rd=13 data=a5a55a5a",
               o_wr_en, o_rd_addr, o_rd_data);
    end
    $display("test_half_word done");
  endtask

  task automatic test_x0();
    drive_alu(5'd0, 32'h12345678, 1'b1);
    tick();
    idle_inputs();
    checks++;
    if (o_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL x0_alu: got wr=%b expected 0", o_wr_en);
    end
    do_load(5'd0, 3'b010, 2'd0, 32'h87654321);
    checks++;
    if (o_wr_en !== 1'b0 || o_load_fault !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL x0_load: got wr=%b flt=%b rdy=%b expected wr=0 flt=0 rdy=1",
               o_wr_en, o_load_fault, o_ready);
    end
    $display("test_x0 done");
  endtask

  task automatic test_fault();
    // Last real write was LW to x13 with a5a55a5a.
    do_load(5'd14, 3'b010, 2'd1, 32'h01020304);
    checks++;
    if (o_load_fault !== 1'b1 || o_wr_en !== 1'b0 || o_rd_addr !== 5'd13 || o_rd_data !== 32'hA5A55A5A) begin
      failures++;
      $display("FAIL lw_misaligned: got flt=%b wr=%b rd=%0d data=%h expected flt=1 wr=0 rd=13 data=a5a55a5a",
               o_load_fault, o_wr_en, o_rd_addr, o_rd_data);
    end
    tick();
    checks++;
    if (o_load_fault !== 1'b0) begin
      failures++;
      $display("FAIL fault_pulse: got flt=%b expected 0", o_load_fault);
    end
    do_load(5'd15, 3'b101, 2'd3, 32'h01020304);
    checks++;
    if (o_load_fault !== 1'b1 || o_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL lhu_misaligned: got flt=%b wr=%b expected flt=1 wr=0", o_load_fault, o_wr_en);
    end
    do_load(5'd16, 3'b011, 2'd0, 32'h01020304);
    checks++;
    if (o_load_fault !== 1'b1 || o_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL funct3_011: got flt=%b wr=%b expected flt=1 wr=0", o_load_fault, o_wr_en);
    end
    do_load(5'd17, 3'b110, 2'd0, 32'h01020304);
    checks++;
    if (o_load_fault !== 1'b1 || o_rd_data !== 32'hA5A55A5A) begin
      failures++;
      $display("FAIL funct3_110: got flt=%b data=%h expected flt=1 data=a5a55a5a", o_load_fault, o_rd_data);
    end
    $display("test_fault done");
  endtask

  task automatic test_reset_mid_load();
    i_valid   = 1'b1;
    i_is_load = 1'b1;
    i_rd_wen  = 1'b1;
    i_rd_addr = 5'd20;
    i_funct3  = 3'b010;
    i_addr_lo = 2'd0;
    tick();
    idle_inputs();
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_wait_ready: got %b expected 0", o_ready);
    end
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1 || o_rd_data !== 32'd0) begin
      failures++;
      $display("FAIL mid_after_reset: got rdy=%b data=%h expected rdy=1 data=00000000", o_ready, o_rd_data);
    end
    i_dmem_rvalid = 1'b1;
    i_dmem_rdata  = 32'hFEEDFACE;
    tick();
    i_dmem_rvalid = 1'b0;
    checks++;
    if (o_wr_en !== 1'b0 || o_load_fault !== 1'b0 || o_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_late_rvalid: got wr=%b flt=%b rdy=%b expected wr=0 flt=0 rdy=1",
               o_wr_en, o_load_fault, o_ready);
    end
    $display("test_reset_mid_load done");
  endtask

`ifdef WB_INSTRET_EN
  task automatic test_instret();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    checks++;
    if (o_instret !== 64'd0) begin
      failures++;
      $display("FAIL instret_reset: got %0d expected 0", o_instret);
    end
    drive_alu(5'd1, 32'd1, 1'b1);
    tick();
    drive_alu(5'd0, 32'd2, 1'b1);
    tick();
    drive_alu(5'd2, 32'd3, 1'b0);
    tick();
    idle_inputs();
    checks++;
    if (o_instret !== 64'd3) begin
      failures++;
      $display("FAIL instret_alu: got %0d expected 3", o_instret);
    end
    do_load(5'd3, 3'b010, 2'd0, 32'h00000004);
    do_load(5'd4, 3'b010, 2'd2, 32'h00000005);
    tick();
    checks++;
    if (o_instret !== 64'd4) begin
      failures++;
      $display("FAIL instret_total: got %0d expected 4", o_instret);
    end
    $display("test_instret done");
  endtask
`endif

  initial begin
    i_rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_alu();
    test_back_to_back();
    test_lb();
    test_half_word();
    test_x0();
    test_fault();
    test_reset_mid_load();
`ifdef WB_INSTRET_EN
    test_instret();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
